cmd_dispatch_fsm: RTL and testbench
===================================

// Module: cmd_dispatch_fsm
// PURPOSE
//  Read side of the command FIFO: pops one command at a time, decodes it and
//  launches it on the multiplier/ALU datapath, then waits for completion.
//  Sits between the command FIFO (rd_en/Data_out/Out_Busy) and the EC
//  arithmetic units. Only one command is in flight at a time.
// PARAMETERS
//  DATA     4    command word width; equals the FIFO Data parameter
//  CNT_W    16   width of the completed-command counter
//  TMO_W    12   watchdog counter width; used only with CMD_DISPATCH_TIMEOUT_EN
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  enable       in   1       1 = dispatch allowed; 0 = stop after current cmd
//  fifo_empty   in   1       FIFO Out_Busy (1 = empty)
//  fifo_data    in   DATA    FIFO Data_out (registered, valid 1 cycle after rd_en)
//  fifo_rd_en   out  1       pop request to FIFO, one-cycle pulse
//  op_start     out  1       one-cycle launch pulse to datapath
//  op_code      out  DATA    command being executed; held stable until op_done
//  op_done      in   1       datapath completion pulse
//  busy         out  1       1 in any state except IDLE
//  cmd_count    out  CNT_W   number of commands retired, NOP included
//  timeout_err  out  1       sticky watchdog flag (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; fifo_rd_en=0, op_start=0, op_code=0,
//    busy=0, cmd_count=0, timeout_err=0. Reset mid-command abandons it; no
//    op_start is re-issued and the popped word is lost.
//  - Moore FSM, outputs decoded from registered state/regs:
//    IDLE : enable && !fifo_empty -> POP; else stay.
//    POP  : fifo_rd_en=1 for exactly this cycle -> LATCH.
//    LATCH: op_code <= fifo_data (FIFO output valid now) -> ISSUE.
//    ISSUE: op_code==0 (NOP): cmd_count++, -> IDLE, no op_start.
//           else op_start=1 this cycle -> WAIT.
//    WAIT : op_done -> cmd_count++, -> IDLE. op_done in any other state ignored.
//  - Latency: fifo_empty falling (with enable=1, in IDLE) to op_start = 3 cycles
//    (POP, LATCH, ISSUE). Min per-command period: 4 cycles + datapath time.
//  - At most one fifo_rd_en per command; never asserted while fifo_empty=1
//    (guard re-checked in IDLE only; FIFO cannot go empty except by our pops).
//  - op_done in same cycle as op_start is ignored; datapath done >=1 cycle later.
//  - enable deasserted mid-command: current command completes; no new pop.
//  - cmd_count wraps modulo 2^CNT_W silently.
// CONFIGURATION
//  CMD_DISPATCH_TIMEOUT_EN defined: TMO_W-bit counter clears on entering WAIT,
//   increments each WAIT cycle; at all-ones, timeout_err<=1 (sticky until
//   reset), state -> IDLE, cmd_count not incremented.
//  Not defined: no counter; WAIT holds forever; timeout_err tied to 0.
// STRUCTURE
//  Shared package ecc_cmd_pkg: state encodings (IDLE..WAIT, 3 bits) and opcode
//   constants (OP_NOP=0, OP_MUL, OP_ADD, OP_SQR, ...) shared with FIFO writer.
//  Single flat module; watchdog is inline under the macro, no sub-module.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT -> all outputs 0 immediately, state IDLE.
//  2 Single cmd 4'h3 written to FIFO, enable=1 -> fifo_rd_en 1 pulse, op_start
//    3 cycles after empty falls, op_code=4'h3; op_done -> cmd_count=1, busy=0.
//  3 NOP 4'h0 -> no op_start, cmd_count increments by 1, back to IDLE.
//  4 Eight cmds 1..8 back-to-back, op_done 5 cycles after each op_start ->
//    op_codes issued in order 1..8, exactly 8 rd_en pulses, cmd_count=8.
//  5 enable=0 during WAIT of cmd 2 of 3 -> cmd 2 retires, no 3rd pop until
//    enable=1, then cmd 3 issues.
//  6 TIMEOUT_EN, TMO_W=4, op_done withheld -> timeout_err=1 after 15 WAIT
//    cycles, state IDLE, cmd_count unchanged; next cmd still dispatches.

Source files
------------

// File: rtl/ecc_cmd_pkg.sv
// Shared encodings for the EC command path: dispatcher FSM states and opcode values.
// Both the FIFO writer and cmd_dispatch_fsm use these definitions.
package ecc_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPop   = 3'd1,
        StLatch = 3'd2,
        StIssue = 3'd3,
        StWait  = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MUL = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SQR = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;

endpackage

// File: rtl/cmd_dispatch_fsm.sv
// Command FIFO read side: pop, latch, launch one command and wait for completion.
// Optional watchdog on the WAIT state is enabled with `define CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatch_fsm
    import ecc_cmd_pkg::*;
#(
    parameter int unsigned DATA  = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DATA-1:0]  fifo_data,
    output logic             fifo_rd_en,
    output logic             op_start,
    output logic [DATA-1:0]  op_code,
    input  logic             op_done,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count,
    output logic             timeout_err
);

    if (TMO_W < 2 || CNT_W < 1 || DATA < 1) begin : g_param_check
        $error("cmd_dispatch_fsm: illegal parameter value");
    end

    state_e           r_state;
    state_e           w_state_d;
    logic [DATA-1:0]  r_op_code;
    logic [CNT_W-1:0] r_cmd_count;
    logic             w_is_nop;
    logic             w_retire;
    logic             w_timeout;

    assign w_is_nop = (r_op_code == DATA'(OP_NOP));

`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic             r_timeout_err;

    assign w_tmo_next = r_tmo + TMO_W'(1);
    // Fires on the WAIT cycle whose increment lands on all-ones; completion wins a tie.
    assign w_timeout  = (r_state == StWait) && !op_done && (w_tmo_next == {TMO_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == StIssue) begin
                r_tmo <= '0;
            end else if (r_state == StWait) begin
                r_tmo <= w_tmo_next;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_retire  = 1'b0;
        case (r_state)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    w_state_d = StPop;
                end
            end
            StPop:   w_state_d = StLatch;
            StLatch: w_state_d = StIssue;
            StIssue: begin
                if (w_is_nop) begin
                    w_state_d = StIdle;
                    w_retire  = 1'b1;
                end else begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (op_done) begin
                    w_state_d = StIdle;
                    w_retire  = 1'b1;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op_code   <= '0;
            r_cmd_count <= '0;
        end else begin
            r_state <= w_state_d;
            // FIFO output is registered, so the popped word is valid during LATCH.
            if (r_state == StLatch) begin
                r_op_code <= fifo_data;
            end
            if (w_retire) begin
                r_cmd_count <= r_cmd_count + CNT_W'(1);
            end
        end
    end

    assign fifo_rd_en = (r_state == StPop);
    assign op_start   = (r_state == StIssue) && !w_is_nop;
    assign op_code    = r_op_code;
    assign busy       = (r_state != StIdle);
    assign cmd_count  = r_cmd_count;

endmodule

// File: tb/tb_cmd_dispatch_fsm.sv
// Directed self-checking bench for cmd_dispatch_fsm with a small registered-output FIFO model.
// The watchdog scenario runs only when CMD_DISPATCH_TIMEOUT_EN is defined.
module tb_cmd_dispatch_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [3:0]  fifo_data;
    logic        fifo_rd_en;
    logic        op_start;
    logic [3:0]  op_code;
    logic        op_done;
    logic        busy;
    logic [15:0] cmd_count;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [3:0] fifo_mem[$];
    logic [3:0] issued[$];
    int         n_rd       = 0;
    int         n_start    = 0;
    int         n_rd_empty = 0;
    logic [15:0] exp_count = 16'd0;

    cmd_dispatch_fsm #(
        .DATA  (4),
        .CNT_W (16),
        .TMO_W (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_en  (fifo_rd_en),
        .op_start    (op_start),
        .op_code     (op_code),
        .op_done     (op_done),
        .busy        (busy),
        .cmd_count   (cmd_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // FIFO model: Data_out registered, valid the cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_mem.size() > 0) begin
            fifo_data <= fifo_mem.pop_front();
            if (fifo_mem.size() == 0) fifo_empty <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                n_rd++;
                if (fifo_empty) n_rd_empty++;
            end
            if (op_start) begin
                n_start++;
                issued.push_back(op_code);
            end
        end
    end

    task automatic push(input logic [3:0] d);
        fifo_mem.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (op_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_data = 4'h0; op_done = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({fifo_rd_en, op_start, op_code, busy, cmd_count, timeout_err} !== 24'h0)
            $display("FAIL reset_outputs: got rd=%b st=%b code=%h busy=%b cnt=%0d tmo=%b want all 0",
                     fifo_rd_en, op_start, op_code, busy, cmd_count, timeout_err);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_single();
        int rd0 = n_rd;
        enable = 1'b1;
        push(4'h3);
        @(negedge clk);
        n_total++;
        if ({fifo_rd_en, op_start} !== 2'b10)
            $display("FAIL single_pop: got rd=%b st=%b want rd=1 st=0", fifo_rd_en, op_start);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({fifo_rd_en, op_start, busy} !== 3'b001)
            $display("FAIL single_latch: got rd=%b st=%b busy=%b want 0 0 1",
                     fifo_rd_en, op_start, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({op_start, op_code} !== {1'b1, 4'h3})
            $display("FAIL single_issue: got st=%b code=%h want st=1 code=3", op_start, op_code);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({op_start, busy} !== 2'b01)
            $display("FAIL single_wait: got st=%b busy=%b want 0 1", op_start, busy);
        else n_pass++;
        pulse_done();
        exp_count++;
        n_total++;
        if ({busy, cmd_count} !== {1'b0, exp_count})
            $display("FAIL single_retire: got busy=%b cnt=%0d want 0 %0d", busy, cmd_count, exp_count);
        else n_pass++;
        n_total++;
        if (n_rd - rd0 !== 1) $display("FAIL single_rd_pulses: got %0d want 1", n_rd - rd0);
        else n_pass++;
    endtask

    task automatic test_nop();
        int st0 = n_start;
        push(4'h0);
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, op_start, op_code} !== {1'b1, 1'b0, 4'h0})
            $display("FAIL nop_issue: got busy=%b st=%b code=%h want 1 0 0", busy, op_start, op_code);
        else n_pass++;
        @(negedge clk);
        exp_count++;
        n_total++;
        if ({busy, cmd_count} !== {1'b0, exp_count})
            $display("FAIL nop_retire: got busy=%b cnt=%0d want 0 %0d", busy, cmd_count, exp_count);
        else n_pass++;
        n_total++;
        if (n_start - st0 !== 0) $display("FAIL nop_no_start: got %0d starts want 0", n_start - st0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rd0 = n_rd;
        bit ok;
        issued.delete();
        for (int i = 1; i <= 8; i++) push(4'(i));
        for (int i = 1; i <= 8; i++) begin
            wait_start(ok);
            n_total++;
            if (!ok) $display("FAIL b2b_start_timeout: cmd %0d got no op_start want op_start", i);
            else n_pass++;
            repeat (4) @(negedge clk);
            pulse_done();
        end
        repeat (2) @(negedge clk);
        exp_count += 16'd8;
        n_total++;
        if (issued.size() !== 8) $display("FAIL b2b_issue_count: got %0d want 8", issued.size());
        else n_pass++;
        for (int i = 0; i < issued.size() && i < 8; i++) begin
            n_total++;
            if (issued[i] !== 4'(i + 1))
                $display("FAIL b2b_order[%0d]: got %h want %h", i, issued[i], 4'(i + 1));
            else n_pass++;
        end
        n_total++;
        if (n_rd - rd0 !== 8) $display("FAIL b2b_rd_pulses: got %0d want 8", n_rd - rd0);
        else n_pass++;
        n_total++;
        if (cmd_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", cmd_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_enable_gate();
        int rd0 = n_rd;
        int st0 = n_start;
        bit ok;
        push(4'h5); push(4'h6); push(4'h7);
        wait_start(ok);
        repeat (2) @(negedge clk);
        pulse_done();
        wait_start(ok);
        n_total++;
        if (!ok || op_code !== 4'h6)
            $display("FAIL gate_cmd2: got ok=%b code=%h want ok=1 code=6", ok, op_code);
        else n_pass++;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        pulse_done();
        repeat (10) @(negedge clk);
        exp_count += 16'd2;
        n_total++;
        if ({busy, cmd_count} !== {1'b0, exp_count})
            $display("FAIL gate_cmd2_retire: got busy=%b cnt=%0d want 0 %0d", busy, cmd_count, exp_count);
        else n_pass++;
        n_total++;
        if (n_rd - rd0 !== 2 || n_start - st0 !== 2 || fifo_empty !== 1'b0)
            $display("FAIL gate_hold: got rd=%0d st=%0d empty=%b want 2 2 0",
                     n_rd - rd0, n_start - st0, fifo_empty);
        else n_pass++;
        enable = 1'b1;
        wait_start(ok);
        n_total++;
        if (!ok || op_code !== 4'h7)
            $display("FAIL gate_cmd3: got ok=%b code=%h want ok=1 code=7", ok, op_code);
        else n_pass++;
        @(negedge clk);
        pulse_done();
        exp_count++;
        n_total++;
        if (cmd_count !== exp_count) $display("FAIL gate_count: got %0d want %0d", cmd_count, exp_count);
        else n_pass++;
    endtask

`ifdef CMD_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        push(4'h2);
        wait_start(ok);
        repeat (15) @(negedge clk);
        n_total++;
        if ({busy, timeout_err} !== 2'b10)
            $display("FAIL tmo_wait15: got busy=%b err=%b want 1 0", busy, timeout_err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, timeout_err, cmd_count} !== {1'b0, 1'b1, exp_count})
            $display("FAIL tmo_fire: got busy=%b err=%b cnt=%0d want 0 1 %0d",
                     busy, timeout_err, cmd_count, exp_count);
        else n_pass++;
        push(4'h4);
        wait_start(ok);
        n_total++;
        if (!ok || op_code !== 4'h4)
            $display("FAIL tmo_next_cmd: got ok=%b code=%h want ok=1 code=4", ok, op_code);
        else n_pass++;
        @(negedge clk);
        pulse_done();
        exp_count++;
        n_total++;
        if ({timeout_err, cmd_count} !== {1'b1, exp_count})
            $display("FAIL tmo_sticky: got err=%b cnt=%0d want 1 %0d", timeout_err, cmd_count, exp_count);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_wait();
        int st0;
        bit ok;
        push(4'h9);
        wait_start(ok);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL rst_pre_wait: got busy=%b want 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({fifo_rd_en, op_start, op_code, busy, cmd_count, timeout_err} !== 24'h0)
            $display("FAIL rst_async: got rd=%b st=%b code=%h busy=%b cnt=%0d tmo=%b want all 0",
                     fifo_rd_en, op_start, op_code, busy, cmd_count, timeout_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        st0 = n_start;
        repeat (8) @(negedge clk);
        n_total++;
        if (n_start - st0 !== 0 || busy !== 1'b0 || fifo_empty !== 1'b1)
            $display("FAIL rst_abandon: got starts=%0d busy=%b empty=%b want 0 0 1",
                     n_start - st0, busy, fifo_empty);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_nop();
        test_back_to_back();
        test_enable_gate();
`ifdef CMD_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        n_total++;
        if (n_rd_empty !== 0) $display("FAIL rd_while_empty: got %0d want 0", n_rd_empty);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
